// File: rtl/mfhi_mflo_control.sv
// Moore control unit: fetches an instruction, then executes mfhi / mflo / nop / halt.
// Optional macro CU_MEMWAIT_EN: T1 stretches until mem_rdy reports valid read data.
module mfhi_mflo_control (
    input  logic        clock,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic [31:0] enc_input,
    output logic [31:0] reg_enable,
    output logic        incPC,
    output logic        read,
    output logic        write,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        conIn,
    output logic [3:0]  Gra,
    output logic [3:0]  Grb,
    output logic [3:0]  Grc,
    output logic [5:0]  ALU_Sel,
    output logic        run,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int SEL_HI  = 16;
    localparam int SEL_LO  = 17;
    localparam int SEL_PC  = 20;
    localparam int SEL_MDR = 22;
    localparam int EN_IR   = 21;
    localparam int EN_MDR  = 22;
    localparam int EN_MAR  = 23;

    state_t      state_q, state_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic        illegal_q, illegal_d;
    logic [4:0]  opcode_s;
    logic [3:0]  ra_s;
    logic        known_op_s;
    logic        unused_ir_s;

    assign opcode_s = ir[31:27];
    assign ra_s     = ir[26:23];
    assign known_op_s = (opcode_s == OP_MFHI) || (opcode_s == OP_MFLO) ||
                        (opcode_s == OP_NOP)  || (opcode_s == OP_HALT);

`ifdef CU_MEMWAIT_EN
    assign unused_ir_s = ^ir[22:0];
`else
    assign unused_ir_s = ^{ir[22:0], mem_rdy};
`endif

    // State, retired-instruction counter and sticky illegal flag
    always_ff @(posedge clock) begin
        if (clr) begin
            state_q       <= ST_RST;
            instr_count_q <= 16'd0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
            illegal_q     <= illegal_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1: begin
`ifdef CU_MEMWAIT_EN
                if (mem_rdy) begin
                    state_d = ST_T2;
                end else begin
                    state_d = ST_T1;
                end
`else
                state_d = ST_T2;
`endif
            end
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (opcode_s == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // Every T3 edge retires one instruction; unknown opcodes latch the flag
    always_comb begin
        if (state_q == ST_T3) begin
            instr_count_d = instr_count_q + 16'd1;
            illegal_d     = illegal_q | ~known_op_s;
        end else begin
            instr_count_d = instr_count_q;
            illegal_d     = illegal_q;
        end
    end

    // Moore output decode from present state (and ir in T3)
    always_comb begin
        enc_input  = 32'd0;
        reg_enable = 32'd0;
        incPC      = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        BAout      = 1'b0;
        conIn      = 1'b0;
        Gra        = 4'd0;
        Grb        = 4'd0;
        Grc        = 4'd0;
        ALU_Sel    = 6'd0;
        run        = 1'b1;
        case (state_q)
            ST_T0: begin
                enc_input[SEL_PC]  = 1'b1;
                reg_enable[EN_MAR] = 1'b1;
                incPC              = 1'b1;
            end
            ST_T1: begin
                read               = 1'b1;
                reg_enable[EN_MDR] = 1'b1;
            end
            ST_T2: begin
                enc_input[SEL_MDR] = 1'b1;
                reg_enable[EN_IR]  = 1'b1;
            end
            ST_T3: begin
                case (opcode_s)
                    OP_MFHI: begin
                        enc_input[SEL_HI] = 1'b1;
                        Rin               = 1'b1;
                        Gra               = ra_s;
                    end
                    OP_MFLO: begin
                        enc_input[SEL_LO] = 1'b1;
                        Rin               = 1'b1;
                        Gra               = ra_s;
                    end
                    default: begin
                        Rin = 1'b0;
                    end
                endcase
            end
            ST_HALT: run = 1'b0;
            default: run = 1'b1;
        endcase
    end

    assign illegal     = illegal_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mfhi_mflo_control.sv
// Scoreboard bench for mfhi_mflo_control: expected output vectors are queued per cycle
// and compared on the falling edge.
module tb_mfhi_mflo_control;

    localparam int P_RST     = 0;
    localparam int P_T0      = 1;
    localparam int P_T1      = 2;
    localparam int P_T2      = 3;
    localparam int P_T3_HI   = 4;
    localparam int P_T3_LO   = 5;
    localparam int P_T3_NONE = 6;
    localparam int P_T3_ILL  = 7;
    localparam int P_HALT    = 8;

    logic        clock;
    logic        clr;
    logic [31:0] ir;
    logic        mem_rdy;
    logic [31:0] enc_input;
    logic [31:0] reg_enable;
    logic        incPC, read, write, Rin, Rout, BAout, conIn;
    logic [3:0]  Gra, Grb, Grc;
    logic [5:0]  ALU_Sel;
    logic        run, illegal;
    logic [15:0] instr_count;

    logic [106:0] obs;
    logic [106:0] sb[$];
    logic [15:0]  m_cnt;
    logic         m_ill;
    int           checks;
    int           failures;

    mfhi_mflo_control dut (
        .clock(clock), .clr(clr), .ir(ir), .mem_rdy(mem_rdy),
        .enc_input(enc_input), .reg_enable(reg_enable),
        .incPC(incPC), .read(read), .write(write), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .conIn(conIn), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .ALU_Sel(ALU_Sel), .run(run), .illegal(illegal), .instr_count(instr_count)
    );

    assign obs = {enc_input, reg_enable, incPC, read, write, Rin, Rout, BAout, conIn,
                  Gra, Grb, Grc, ALU_Sel, run, illegal, instr_count};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [106:0] exp_vec(input int ph, input logic [3:0] ra,
                                             input logic ill, input logic [15:0] cnt);
        logic [31:0] enc, ren;
        logic        inc, rd, rin, rn;
        logic [3:0]  gra;
        enc = 32'h0; ren = 32'h0; inc = 1'b0; rd = 1'b0; rin = 1'b0; rn = 1'b1; gra = 4'h0;
        case (ph)
            P_T0:    begin enc = 32'h0010_0000; ren = 32'h0080_0000; inc = 1'b1; end
            P_T1:    begin rd = 1'b1; ren = 32'h0040_0000; end
            P_T2:    begin enc = 32'h0040_0000; ren = 32'h0020_0000; end
            P_T3_HI: begin enc = 32'h0001_0000; rin = 1'b1; gra = ra; end
            P_T3_LO: begin enc = 32'h0002_0000; rin = 1'b1; gra = ra; end
            P_HALT:  rn = 1'b0;
            default: rn = 1'b1;
        endcase
        return {enc, ren, inc, rd, 1'b0, rin, 1'b0, 1'b0, 1'b0,
                gra, 4'h0, 4'h0, 6'h00, rn, ill, cnt};
    endfunction

    // Queue one cycle's expectation and advance the bench's own counter/flag model.
    task automatic push(input int ph, input logic [3:0] ra);
        sb.push_back(exp_vec(ph, ra, m_ill, m_cnt));
        if (ph >= P_T3_HI && ph <= P_T3_ILL) m_cnt = m_cnt + 16'd1;
        if (ph == P_T3_ILL) m_ill = 1'b1;
    endtask

    task automatic test_reset();
        logic [106:0] e;
        clr = 1'b1; ir = 32'h0; mem_rdy = 1'b1;
        m_cnt = 16'd0; m_ill = 1'b0;
        push(P_RST, 4'h0); push(P_RST, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL reset got=%h exp=%h", obs, e); end
        end
        clr = 1'b0;
    endtask

    task automatic test_mfhi();
        logic [106:0] e;
        ir = 32'hC100_0000;
        push(P_T0, 4'h0); push(P_T1, 4'h0); push(P_T2, 4'h0);
        push(P_T3_HI, 4'h2); push(P_T0, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL mfhi got=%h exp=%h", obs, e); end
        end
    endtask

    task automatic test_mflo();
        logic [106:0] e;
        ir = 32'hC980_0000;
        push(P_T1, 4'h0); push(P_T2, 4'h0); push(P_T3_LO, 4'h3); push(P_T0, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL mflo got=%h exp=%h", obs, e); end
        end
    endtask

    task automatic test_memwait();
        logic [106:0] e;
        ir = 32'hD000_0000;
        mem_rdy = 1'b0;
`ifdef CU_MEMWAIT_EN
        for (int i = 0; i < 4; i++) push(P_T1, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL memwait_hold got=%h exp=%h", obs, e); end
        end
        mem_rdy = 1'b1;
`else
        push(P_T1, 4'h0);
`endif
        push(P_T2, 4'h0); push(P_T3_NONE, 4'h0); push(P_T0, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL memwait got=%h exp=%h", obs, e); end
        end
        mem_rdy = 1'b1;
    endtask

    task automatic test_halt();
        logic [106:0] e;
        ir = 32'hD800_0000;
        push(P_T1, 4'h0); push(P_T2, 4'h0); push(P_T3_NONE, 4'h0);
        for (int i = 0; i < 10; i++) push(P_HALT, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL halt got=%h exp=%h", obs, e); end
        end
        clr = 1'b1; m_cnt = 16'd0; m_ill = 1'b0;
        push(P_RST, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL halt_clr got=%h exp=%h", obs, e); end
        end
        clr = 1'b0;
        push(P_T0, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL halt_exit got=%h exp=%h", obs, e); end
        end
    endtask

    task automatic test_illegal();
        logic [106:0] e;
        ir = 32'h0000_0000;
        for (int i = 0; i < 2; i++) begin
            push(P_T1, 4'h0); push(P_T2, 4'h0); push(P_T3_ILL, 4'h0); push(P_T0, 4'h0);
        end
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL illegal got=%h exp=%h", obs, e); end
        end
    endtask

    task automatic test_nop_sticky();
        logic [106:0] e;
        ir = 32'hD000_0000;
        push(P_T1, 4'h0); push(P_T2, 4'h0); push(P_T3_NONE, 4'h0); push(P_T0, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL nop_sticky got=%h exp=%h", obs, e); end
        end
    endtask

    task automatic test_clr_mid_fetch();
        logic [106:0] e;
        ir = 32'hC100_0000;
        push(P_T1, 4'h0); push(P_T2, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL clr_pre got=%h exp=%h", obs, e); end
        end
        clr = 1'b1; m_cnt = 16'd0; m_ill = 1'b0;
        push(P_RST, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL clr_t2 got=%h exp=%h", obs, e); end
        end
        clr = 1'b0;
        push(P_T0, 4'h0); push(P_T1, 4'h0); push(P_T2, 4'h0); push(P_T3_HI, 4'h2); push(P_T0, 4'h0);
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL clr_resume got=%h exp=%h", obs, e); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_mfhi();
        test_mflo();
        test_memwait();
        test_halt();
        test_illegal();
        test_nop_sticky();
        test_clr_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
